msrv32_instr_fetch_queue: RTL and testbench

- Fetch stage directly upstream of the decoder and immediate generator. Generates sequential fetch PCs and issues reads to a synchronous instruction memory with 1-cycle latency.
- Buffers returned words with their PCs in a small FIFO.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- A flush (branch, jump or trap redirect) drops all buffered and in-flight words and restarts fetch at a new PC.

---
 rtl/msrv32_instr_fetch_queue_pkg.sv | 11 +
 rtl/msrv32_instr_fetch_queue_fifo.sv | 47 ++++
 rtl/msrv32_instr_fetch_queue.sv | 80 ++++++++
 tb/tb_msrv32_instr_fetch_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/msrv32_instr_fetch_queue_pkg.sv
// msrv32_pkg: shared RV32 constants and the fetch-queue entry types.
package msrv32_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef logic [XLEN-1:0] instr_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        instr_t          instr;
    } ifq_entry_t;
endpackage

// File: rtl/msrv32_instr_fetch_queue_fifo.sv
// msrv32_sync_fifo: generic synchronous circular buffer with clear; DEPTH must be a power of two.
module msrv32_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_comb begin
        wr_ptr_d = clear_i ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = clear_i ? '0 : rd_ptr_q + AW'(do_pop);
        count_d  = clear_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/msrv32_instr_fetch_queue.sv
// msrv32_instr_fetch_queue: sequential fetch into a small FIFO feeding decode over valid/ready.
// Define MSRV32_IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module msrv32_instr_fetch_queue
    import msrv32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] flush_pc_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic [XLEN-1:0] imem_rdata_in,
    output logic            instr_valid_out,
    input  logic            instr_ready_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, issued_pc_q, issued_pc_d, pc_last_q, pc_last_d;
    logic inflight_q, inflight_d, discard_q, discard_d;
    logic [CW-1:0] count;
    logic fifo_empty, unused_full, resp_valid, bypass, push, pop;
    logic [1:0] unused_pc_lsb;
    ifq_entry_t push_entry, head_entry;
    assign unused_pc_lsb = flush_pc_in[1:0];
    // Credits count in-flight reads so a response always has a free slot.
    assign imem_req_out  = !rst_in && !flush_in &&
                           (({1'b0, count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH));
    assign imem_addr_out = fetch_pc_q;
    assign resp_valid    = inflight_q && !discard_q && !flush_in;
`ifdef MSRV32_IFQ_BYPASS_EN
    assign bypass = fifo_empty && resp_valid;
`else
    assign bypass = 1'b0;
`endif
    assign instr_valid_out = !fifo_empty || bypass;
    assign instr_out = !fifo_empty ? head_entry.instr : bypass ? imem_rdata_in : NOP;
    assign pc_out    = !fifo_empty ? head_entry.pc : bypass ? issued_pc_q : pc_last_q;
    assign pop       = !fifo_empty && instr_ready_in && !flush_in;
    assign push      = resp_valid && !(bypass && instr_ready_in);
    assign push_entry = '{pc: issued_pc_q, instr: imem_rdata_in};
    always_comb begin
        fetch_pc_d  = flush_in ? {flush_pc_in[XLEN-1:2], 2'b00} :
                      imem_req_out ? fetch_pc_q + 32'd4 : fetch_pc_q;
        issued_pc_d = imem_req_out ? fetch_pc_q : issued_pc_q;
        inflight_d  = imem_req_out;
        discard_d   = flush_in && inflight_q;
        pc_last_d   = pc_out;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            discard_q   <= 1'b0;
            pc_last_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            pc_last_q   <= pc_last_d;
        end
    end
    msrv32_sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .clear_i (flush_in),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (count),
        .full_o  (unused_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_msrv32_instr_fetch_queue.sv
// tb_msrv32_instr_fetch_queue: directed checks of fetch order, credits, flush, wrap and reset.
module tb_msrv32_instr_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b0;
    logic [31:0] flush_pc = '0, rdata = '0;
    logic req, valid;
    logic [31:0] addr, instr, pc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rdata <= req ? (addr ^ K) : 32'hDEAD_BEEF;

    msrv32_instr_fetch_queue dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .flush_in        (flush),
        .flush_pc_in     (flush_pc),
        .imem_req_out    (req),
        .imem_addr_out   (addr),
        .imem_rdata_in   (rdata),
        .instr_valid_out (valid),
        .instr_ready_in  (ready),
        .instr_out       (instr),
        .pc_out          (pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, " req"}, 32'(req), 32'(r));
        if (r) chk({tag, " addr"}, addr, a);
    endtask

    task automatic exp_valid(input string tag, input logic [31:0] p);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " pc"}, pc, p);
        chk({tag, " instr"}, instr, p ^ K);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, " valid"}, 32'(valid), 32'd0);
        chk({tag, " nop"}, instr, 32'h0000_0013);
    endtask

    task automatic reset_dut(input logic rdy);
        rst = 1'b1;
        flush = 1'b0;
        ready = rdy;
        cyc;
        cyc;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        cyc;
        cyc;
        exp_idle("rst");
        exp_req("rst", 1'b0, 32'h0);
        chk("rst pc", pc, 32'h0);
        // Streaming from reset with ready high
        ready = 1'b1;
        rst = 1'b0;
        #1;
        exp_req("t1 R", 1'b1, 32'h0);
        cyc; exp_req("t1 R1", 1'b1, 32'h4); exp_idle("t1 R1");
        cyc; exp_req("t1 R2", 1'b1, 32'h8); exp_valid("t1 R2", 32'h0);
        cyc; exp_req("t1 R3", 1'b1, 32'hC); exp_valid("t1 R3", 32'h4);
        cyc; exp_valid("t1 R4", 32'h8);
        // Back-pressure: four credits then stall
        reset_dut(1'b0);
        exp_req("t2 R", 1'b1, 32'h0);
        cyc; exp_req("t2 R1", 1'b1, 32'h4);
        cyc; exp_req("t2 R2", 1'b1, 32'h8);
        cyc; exp_req("t2 R3", 1'b1, 32'hC);
        cyc; exp_req("t2 R4", 1'b0, 32'h0); exp_valid("t2 R4", 32'h0);
        cyc; exp_req("t2 R5", 1'b0, 32'h0);
        ready = 1'b1;
        #1;
        exp_valid("t2 R5", 32'h0);
        exp_req("t2 R5b", 1'b0, 32'h0);
        cyc; exp_req("t2 R6", 1'b1, 32'h10); exp_valid("t2 R6", 32'h4);
        cyc; exp_req("t2 R7", 1'b1, 32'h14); exp_valid("t2 R7", 32'h8);
        cyc; exp_valid("t2 R8", 32'hC);
        cyc; exp_valid("t2 R9", 32'h10);
        // Flush with an entry queued and a read in flight
        reset_dut(1'b1);
        cyc;
        cyc; exp_valid("t3 R2", 32'h0);
        cyc; exp_valid("t3 T", 32'h4);
        flush = 1'b1;
        flush_pc = 32'h0000_0102;
        #1;
        exp_req("t3 T", 1'b0, 32'h0);
        cyc;
        flush = 1'b0;
        #1;
        exp_req("t3 T1", 1'b1, 32'h100); exp_idle("t3 T1");
        chk("t3 T1 held pc", pc, 32'h4);
        cyc; exp_req("t3 T2", 1'b1, 32'h104); exp_idle("t3 T2");
        cyc; exp_valid("t3 T3", 32'h100);
        cyc; exp_valid("t3 T4", 32'h104);
        // Push and pop together at count 3
        reset_dut(1'b0);
        cyc; cyc; cyc; cyc;
        exp_req("t4 R4", 1'b0, 32'h0);
        ready = 1'b1;
        #1;
        exp_valid("t4 R4", 32'h0);
        cyc; exp_req("t4 R5", 1'b1, 32'h10); exp_valid("t4 R5", 32'h4);
        cyc; exp_valid("t4 R6", 32'h8);
        cyc; exp_valid("t4 R7", 32'hC);
        cyc; exp_valid("t4 R8", 32'h10);
        // Flush to the top word, fetch PC wraps to zero
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        #1;
        exp_req("t5 T", 1'b0, 32'h0);
        cyc;
        flush = 1'b0;
        #1;
        exp_req("t5 T1", 1'b1, 32'hFFFF_FFFC); exp_idle("t5 T1");
        cyc; exp_req("t5 T2", 1'b1, 32'h0);
        cyc; exp_valid("t5 T3", 32'hFFFF_FFFC);
        cyc; exp_valid("t5 T4", 32'h0);
        // Reset pulse with a loaded queue and a read in flight
        reset_dut(1'b0);
        cyc; cyc; cyc; cyc;
        exp_valid("t6 R4", 32'h0);
        rst = 1'b1;
        #1;
        exp_req("t6 X", 1'b0, 32'h0);
        cyc;
        rst = 1'b0;
        #1;
        exp_idle("t6 X1");
        chk("t6 X1 pc", pc, 32'h0);
        exp_req("t6 X1", 1'b1, 32'h0);
        cyc; exp_idle("t6 X2"); exp_req("t6 X2", 1'b1, 32'h4);
        cyc; exp_valid("t6 X3", 32'h0);
        // Same again with flush asserted alongside reset
        cyc;
        rst = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h0000_0200;
        #1;
        exp_req("t6b X", 1'b0, 32'h0);
        cyc;
        rst = 1'b0;
        flush = 1'b0;
        #1;
        exp_idle("t6b X1");
        exp_req("t6b X1", 1'b1, 32'h0);
        cyc; exp_idle("t6b X2"); exp_req("t6b X2", 1'b1, 32'h4);
        cyc; exp_valid("t6b X3", 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
